// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// The loader sits on the slave side; a stream source and memory model use master.
interface imem_boot_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte frame into 32-bit
// instruction-memory writes and holds the core in reset until the image verifies.
module imem_boot_loader #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 256
) (
  input  logic                clk,
  input  logic                reset,
  imem_boot_loader_if.slave   bus,
  input  logic                restart,
  output logic                core_hold,
  output logic                done,
  output logic                error
);

  typedef enum logic [2:0] {
    StLen0, StLen1, StLenErr, StData, StCheck, StDone, StError
  } state_e;

  state_e            state_q;
  logic              in_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic [31:0]       shift_q;
  logic [1:0]        byte_cnt_q;
  logic [15:0]       len_q;
  logic [15:0]       word_idx_q;
  logic [7:0]        chk_q;
  logic              core_hold_q;
  logic              done_q;
  logic              error_q;

  logic              accept;
  logic [15:0]       len_next;
  logic              len_bad;
  logic [31:0]       word_next;
  logic              last_word;
  logic [ADDR_W-1:0] word_addr;

  always_comb begin
    accept    = bus.in_valid & in_ready_q;
    len_next  = {bus.in_data, len_q[7:0]};
    len_bad   = (len_next == 16'd0) || (32'(len_next) > MAX_WORDS);
    // Bytes arrive LSB first, so each new byte enters at the top and shifts down.
    word_next = {bus.in_data, shift_q[31:8]};
    last_word = (word_idx_q == len_q - 16'd1);
    word_addr = BASE_ADDR + ADDR_W'({word_idx_q, 2'b00});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StLen0;
      in_ready_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE_ADDR;
      imem_wdata_q <= '0;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      len_q        <= '0;
      word_idx_q   <= '0;
      chk_q        <= '0;
      core_hold_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      unique case (state_q)
        StLen0: begin
          if (accept) begin
            len_q[7:0] <= bus.in_data;
            state_q    <= StLen1;
          end
        end
        StLen1: begin
          if (accept) begin
            len_q[15:8] <= bus.in_data;
            if (len_bad) begin
              state_q    <= StLenErr;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= StData;
            end
          end
        end
        StLenErr: begin
          state_q <= StError;
          error_q <= 1'b1;
        end
        StData: begin
          if (accept) begin
            shift_q    <= word_next;
            chk_q      <= chk_q ^ bus.in_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              imem_we_q    <= 1'b1;
              imem_wdata_q <= word_next;
              imem_addr_q  <= word_addr;
              word_idx_q   <= word_idx_q + 16'd1;
              if (last_word) state_q <= StCheck;
            end
          end
        end
        StCheck: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (bus.in_data == chk_q) begin
              state_q     <= StDone;
              done_q      <= 1'b1;
              core_hold_q <= 1'b0;
            end else begin
              state_q <= StError;
              error_q <= 1'b1;
            end
          end
        end
        StDone, StError: begin
          if (restart) begin
            state_q     <= StLen0;
            in_ready_q  <= 1'b1;
            core_hold_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            byte_cnt_q  <= '0;
            word_idx_q  <= '0;
            chk_q       <= '0;
            len_q       <= '0;
          end
        end
        default: begin
          state_q     <= StError;
          in_ready_q  <= 1'b0;
          core_hold_q <= 1'b1;
          error_q     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign core_hold      = core_hold_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: frames are built from word lists and
// the expected write list / outcome is derived from the frame rules directly.
module tb_imem_boot_loader;
  localparam int unsigned AW   = 32;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic restart = 1'b0;
  logic core_hold, done, error;

  imem_boot_loader_if #(.ADDR_W(AW)) bus ();

  imem_boot_loader #(
    .ADDR_W   (AW),
    .BASE_ADDR(BASE),
    .MAX_WORDS(256)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .restart  (restart),
    .core_hold(core_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] words[$];
  logic [7:0]  frame[$];
  logic [63:0] wq[$];
  int          overlap = 0;

  // Write monitor: records every strobe; done or a released core during a write is illegal.
  always @(negedge clk) begin
    if (bus.imem_we) begin
      wq.push_back({bus.imem_addr, bus.imem_wdata});
      if (done || !core_hold) overlap++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void make_frame();
    logic [7:0] chk;
    int n;
    chk = 8'h00;
    n   = words.size();
    frame.delete();
    frame.push_back(8'(n));
    frame.push_back(8'(n >> 8));
    foreach (words[i]) begin
      for (int b = 0; b < 4; b++) begin
        logic [7:0] x;
        x = 8'(words[i] >> (8 * b));
        frame.push_back(x);
        chk ^= x;
      end
    end
    frame.push_back(chk);
  endfunction

  function automatic void rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endfunction

  // Called at a negedge; returns at the negedge after the last byte is taken.
  task automatic send(input int count, input int maxgap);
    for (int i = 0; i < count; i++) begin
      int w;
      bus.in_valid = 1'b0;
      repeat ($urandom_range(maxgap, 0)) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = frame[i];
      w = 0;
      while (!bus.in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!bus.in_ready) begin
        check($sformatf("accept_byte%0d", i), 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int w;
    w = 0;
    while (!(done || error) && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
  endtask

  task automatic pulse_restart(input logic v, input logic [7:0] d);
    restart      = 1'b1;
    bus.in_valid = v;
    bus.in_data  = d;
    @(negedge clk);
    restart      = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    int bad;
    bad = 0;
    check({tag, "_wcount"}, 64'(wq.size()), 64'(words.size()));
    foreach (words[i]) begin
      if (i >= wq.size() || wq[i] !== {BASE + 32'(4 * i), words[i]}) bad++;
    end
    check({tag, "_wvals"}, 64'(bad), 64'd0);
  endtask

  task automatic run_good(input string tag, input int gap);
    make_frame();
    wq.delete();
    overlap = 0;
    send(frame.size(), gap);
    wait_end();
    check_writes(tag);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_hold"}, 64'(core_hold), 64'd0);
    check({tag, "_err"}, 64'(error), 64'd0);
    check({tag, "_ready"}, 64'(bus.in_ready), 64'd0);
    check({tag, "_order"}, 64'(overlap), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_we"}, 64'(bus.imem_we), 64'd0);
    check({tag, "_addr"}, 64'(bus.imem_addr), 64'(BASE));
    check({tag, "_wdata"}, 64'(bus.imem_wdata), 64'd0);
    check({tag, "_hold"}, 64'(core_hold), 64'd1);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(error), 64'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk);

    // Reference two-word image, back-to-back bytes.
    words = '{32'h0050_0013, 32'h00A0_0093};
    run_good("two_word", 0);

    pulse_restart(1'b0, 8'h00);
    check("restart_done_clr", 64'(done), 64'd0);
    check("restart_hold", 64'(core_hold), 64'd1);
    check("restart_ready", 64'(bus.in_ready), 64'd1);

    // Corrupted checksum: writes still happen, then a sticky error.
    make_frame();
    frame[frame.size() - 1] = frame[frame.size() - 1] ^ 8'hFF;
    wq.delete();
    send(frame.size(), 0);
    wait_end();
    check_writes("bad_chk");
    check("bad_chk_err", 64'(error), 64'd1);
    check("bad_chk_done", 64'(done), 64'd0);
    check("bad_chk_hold", 64'(core_hold), 64'd1);
    check("bad_chk_ready", 64'(bus.in_ready), 64'd0);

    // Restart with a byte presented: that byte must be dropped.
    pulse_restart(1'b1, 8'h03);
    check("rst_err_clr", 64'(error), 64'd0);
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    rand_words(3);
    run_good("after_restart", 0);

    // Zero length.
    pulse_restart(1'b0, 8'h00);
    frame = '{8'h00, 8'h00};
    wq.delete();
    send(2, 0);
    wait_end();
    check("len0_err", 64'(error), 64'd1);
    check("len0_nowrite", 64'(wq.size()), 64'd0);

    // One past the maximum word count.
    pulse_restart(1'b0, 8'h00);
    frame = '{8'h01, 8'h01};
    wq.delete();
    send(2, 0);
    wait_end();
    check("len257_err", 64'(error), 64'd1);
    check("len257_nowrite", 64'(wq.size()), 64'd0);
    check("len257_hold", 64'(core_hold), 64'd1);

    // Stalled stream with the reference image.
    pulse_restart(1'b0, 8'h00);
    words = '{32'h0050_0013, 32'h00A0_0093};
    run_good("stall", 3);

    // Random-size random image with gaps.
    pulse_restart(1'b0, 8'h00);
    rand_words($urandom_range(8, 1));
    run_good("rand", 2);

    // Maximum legal size.
    pulse_restart(1'b0, 8'h00);
    rand_words(256);
    run_good("max", 0);
    if (wq.size() == 256) check("max_last_addr", 64'(wq[255][63:32]), 64'h3FC);
    else check("max_last_addr_cnt", 64'(wq.size()), 64'd256);

    // Reset mid-frame after the 6th byte, then a clean reload.
    pulse_restart(1'b0, 8'h00);
    rand_words(2);
    make_frame();
    send(6, 0);
    reset = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    words = '{32'hDEAD_BEEF, 32'h0123_4567};
    run_good("post_reset", 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
